// File: rtl/peripheral_bb_master.sv
// peripheral_bb_master
// Turns a valid/ready request stream into single bus cycles on the 8-bit
// peripheral bus. Requests are queued in a small FIFO and issued one at a
// time. Read data is captured a fixed number of cycles after the strobe and
// returned on a valid/ready response channel.
//
// Read timing: RD_LAT is the number of rising edges between the edge that
// starts the read strobe and the edge that samples din. The latency counter
// is loaded with RD_LAT-1 on the edge that enters RD. It is tested and
// decremented in RD and in RD_WAIT. For RD_LAT=1, din is therefore sampled
// at the end of the strobe cycle and RD_WAIT is skipped. For RD_LAT=N, the
// FSM spends N-1 cycles in RD_WAIT.
module peripheral_bb_master #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1,
  parameter int AW     = 16,
  parameter int DW     = 8
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          cen,
  output logic [1:0]    wen,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  output logic          rw
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [2:0]    LAT_INIT   = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Request FIFO storage, kept as three parallel arrays
  logic          memWrite [DEPTH];
  logic [AW-1:0] memAddr  [DEPTH];
  logic [DW-1:0] memData  [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic          cen_q, cen_d;
  logic [1:0]    wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rw_q, rw_d;
  logic          rspValid_q, rspValid_d;
  logic [DW-1:0] rspRdata_q, rspRdata_d;
  logic [2:0]    latCnt_q, latCnt_d;

  logic          push;
  logic          pop;
  logic          fifoEmpty;
  logic          headWrite;
  logic [AW-1:0] headAddr;
  logic [DW-1:0] headData;

  assign fifoEmpty = (count_q == '0);
  assign req_ready = (count_q != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && !fifoEmpty;

  assign headWrite = memWrite[rdPtr_q];
  assign headAddr  = memAddr[rdPtr_q];
  assign headData  = memData[rdPtr_q];

  // Write accepted requests into the slot at the write pointer
  always_ff @(posedge mclk) begin
    if (push) begin
      memWrite[wrPtr_q] <= req_write;
      memAddr[wrPtr_q]  <= req_addr;
      memData[wrPtr_q]  <= req_wdata;
    end
  end

  // Advance pointers and track occupancy; pointers wrap by natural overflow
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Bus FSM next state; bus outputs are registered so they change on state entry
  always_comb begin
    state_d    = state_q;
    cen_d      = cen_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rw_d       = rw_q;
    rspValid_d = rspValid_q;
    rspRdata_d = rspRdata_q;
    latCnt_d   = latCnt_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          addr_d = headAddr;
          cen_d  = 1'b0;
          if (headWrite) begin
            state_d = WR;
            dout_d  = headData;
            wen_d   = 2'b00;
            rw_d    = 1'b0;
          end else begin
            state_d  = RD;
            dout_d   = '0;
            wen_d    = 2'b11;
            rw_d     = 1'b1;
            latCnt_d = LAT_INIT;
          end
        end
      end
      WR: begin
        state_d = IDLE;
        cen_d   = 1'b1;
        wen_d   = 2'b11;
      end
      RD: begin
        cen_d = 1'b1;
        if (latCnt_q == 3'd0) begin
          rspRdata_d = din;
          rspValid_d = 1'b1;
          rw_d       = 1'b0;
          state_d    = RESP;
        end else begin
          latCnt_d = latCnt_q - 3'd1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (latCnt_q == 3'd0) begin
          rspRdata_d = din;
          rspValid_d = 1'b1;
          rw_d       = 1'b0;
          state_d    = RESP;
        end else begin
          latCnt_d = latCnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        cen_d      = 1'b1;
        wen_d      = 2'b11;
        rw_d       = 1'b0;
        rspValid_d = 1'b0;
      end
    endcase
  end

  // FSM state, bus output and response registers; reset aborts any bus cycle
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cen_q      <= 1'b1;
      wen_q      <= 2'b11;
      addr_q     <= '0;
      dout_q     <= '0;
      rw_q       <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      latCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rw_q       <= rw_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      latCnt_q   <= latCnt_d;
    end
  end

  assign cen       = cen_q;
  assign wen       = wen_q;
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign rw        = rw_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign busy      = !fifoEmpty || (state_q != IDLE);

endmodule

// File: tb/tb_peripheral_bb_master.sv
// Testbench for peripheral_bb_master (DEPTH=4, RD_LAT=2).
// Stimulus pushes the expected bus cycles and read data into queues.
// A monitor on the falling edge pops and compares them against the bus.
module tb_peripheral_bb_master;

  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int AW     = 16;
  localparam int DW     = 8;

  logic          mclk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          cen;
  logic [1:0]    wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;
  logic          rw;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } busOp_t;

  busOp_t        busQ[$];
  logic [DW-1:0] rspQ[$];

  int checks = 0;
  int errors = 0;

  peripheral_bb_master #(
    .DEPTH(DEPTH), .RD_LAT(RD_LAT), .AW(AW), .DW(DW)
  ) dut (
    .mclk(mclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .cen(cen), .wen(wen), .addr(addr), .dout(dout),
    .din(din), .rw(rw)
  );

  // Free-running clock
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Peripheral model: read data is the function of the held bus address
  function automatic logic [DW-1:0] periphData(input logic [AW-1:0] a);
    if (a == 16'h0042) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign din = rw ? periphData(addr) : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one request and record what the bus and response channel must show
  task automatic applyStimulus(input logic write, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    int waitCycles;
    busOp_t op;
    req_valid  = 1'b1;
    req_write  = write;
    req_addr   = a;
    req_wdata  = d;
    waitCycles = 0;
    while (!req_ready && waitCycles < 200) begin
      @(posedge mclk);
      #1;
      waitCycles++;
    end
    if (!req_ready) begin
      checkOutput("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      op.write = write;
      op.addr  = a;
      op.data  = write ? d : 8'h00;
      busQ.push_back(op);
      if (!write) rspQ.push_back(periphData(a));
      @(posedge mclk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < budget) begin
      @(posedge mclk);
      #1;
      n++;
    end
    checkOutput("drain_idle", 32'(busy || rsp_valid), 32'd0);
  endtask

  // Monitor: compare each bus strobe and each response handshake
  logic          prevStrobe = 1'b0;
  logic          prevStall  = 1'b0;
  logic [DW-1:0] prevData   = '0;
  int            rwRun      = 0;
  busOp_t        expOp;
  logic [DW-1:0] expData;

  always @(negedge mclk) begin
    if (rst) begin
      prevStrobe = 1'b0;
      prevStall  = 1'b0;
      rwRun      = 0;
    end else begin
      if (!cen) begin
        if (prevStrobe) checkOutput("strobe_gap", 32'd1, 32'd0);
        if (busQ.size() == 0) begin
          checkOutput("bus_unexpected", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          expOp = busQ.pop_front();
          checkOutput("bus_wen", 32'(wen), expOp.write ? 32'd0 : 32'd3);
          checkOutput("bus_addr", 32'(addr), 32'(expOp.addr));
          checkOutput("bus_dout", 32'(dout), 32'(expOp.data));
          checkOutput("bus_rw", 32'(rw), 32'(!expOp.write));
        end
      end
      prevStrobe = !cen;
      if (rw) begin
        rwRun++;
      end else if (rwRun != 0) begin
        checkOutput("rw_len", 32'(rwRun), 32'(RD_LAT));
        rwRun = 0;
      end
      if (prevStall) begin
        checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_hold_data", 32'(rsp_rdata), 32'(prevData));
      end
      if (rsp_valid && rsp_ready) begin
        if (rspQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_rdata), 32'hFFFF_FFFF);
        end else begin
          expData = rspQ.pop_front();
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(expData));
        end
      end
      prevStall = rsp_valid && !rsp_ready;
      prevData  = rsp_rdata;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cen"}, 32'(cen), 32'd1);
    checkOutput({tag, "_wen"}, 32'(wen), 32'd3);
    checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
    checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
    checkOutput({tag, "_rw"}, 32'(rw), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int cyc, strobeCyc, validCyc, n;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge mclk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge mclk);
    #1;

    $display("[TB] single write");
    applyStimulus(1'b1, 16'h0120, 8'hA5);
    waitIdle(50);

    $display("[TB] single read with latency check");
    applyStimulus(1'b0, 16'h0042, 8'h00);
    cyc = 0; strobeCyc = -1; validCyc = -1;
    while (validCyc < 0 && cyc < 50) begin
      @(posedge mclk);
      #1;
      cyc++;
      if (!cen && strobeCyc < 0) strobeCyc = cyc;
      if (rsp_valid && validCyc < 0) validCyc = cyc;
    end
    checkOutput("rd_latency", 32'(validCyc - strobeCyc), 32'd2);
    waitIdle(50);

    $display("[TB] fifo full with response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0055, 8'h00);
    applyStimulus(1'b1, 16'h0201, 8'h11);
    applyStimulus(1'b1, 16'h0202, 8'h22);
    applyStimulus(1'b1, 16'h0203, 8'h33);
    applyStimulus(1'b1, 16'h0204, 8'h44);
    checkOutput("full_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'hDEAD;
    req_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge mclk);
      #1;
      checkOutput("full_reject", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    waitIdle(100);
    checkOutput("full_busq_empty", 32'(busQ.size()), 32'd0);

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0042, 8'h00);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge mclk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rdata", 32'(rsp_rdata), 32'h3C);
      checkOutput("bp_cen", 32'(cen), 32'd1);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      @(posedge mclk);
      #1;
    end
    rsp_ready = 1'b1;
    waitIdle(50);

    $display("[TB] push/pop at DEPTH-1 and pointer wrap");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0300, 8'h00);
    applyStimulus(1'b1, 16'h0301, 8'h01);
    applyStimulus(1'b1, 16'h0302, 8'h02);
    applyStimulus(1'b1, 16'h0303, 8'h03);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      mw = ((i % 3) != 1);
      ma = 16'(16'h1000 + i * 16'h0111);
      md = 8'(8'h10 + i * 7);
      applyStimulus(mw, ma, md);
    end
    waitIdle(200);
    checkOutput("wrap_busq_empty", 32'(busQ.size()), 32'd0);
    checkOutput("wrap_rspq_empty", 32'(rspQ.size()), 32'd0);

    $display("[TB] reset during read wait");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0400, 8'h00);
    applyStimulus(1'b0, 16'h0401, 8'h00);
    applyStimulus(1'b1, 16'h0402, 8'h12);
    applyStimulus(1'b1, 16'h0403, 8'h34);
    applyStimulus(1'b1, 16'h0404, 8'h56);
    rsp_ready = 1'b1;
    n = 0;
    while (!(rw && cen) && n < 50) begin
      @(posedge mclk);
      #1;
      n++;
    end
    checkOutput("rst_reached_rd_wait", 32'(rw && cen), 32'd1);
    rst = 1'b1;
    busQ.delete();
    rspQ.delete();
    @(posedge mclk);
    #1;
    checkResetState("midrst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge mclk);
      #1;
      checkOutput("post_rst_cen", 32'(cen), 32'd1);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
